// File: rtl/fetch_unit_pkg.sv
// Shared instruction-set constants for the mini 16-bit core (fetch and decode).
package riscv_mini_pkg;

  localparam int          INSTR_W      = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  // Major opcode field values, shared with decode
  localparam logic [2:0] OPC_R = 3'd0;
  localparam logic [2:0] OPC_I = 3'd1;
  localparam logic [2:0] OPC_L = 3'd2;
  localparam logic [2:0] OPC_S = 3'd3;
  localparam logic [2:0] OPC_B = 3'd4;
  localparam logic [2:0] OPC_J = 3'd5;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode handoff.
interface fetch_unit_if #(
  parameter int PC_W = 16
);
  logic                               imem_req_o;
  logic [PC_W-1:0]                    imem_addr_o;
  logic                               imem_gnt_i;
  logic                               imem_rvalid_i;
  logic [riscv_mini_pkg::INSTR_W-1:0] imem_rdata_i;
  logic                               instr_valid_o;
  logic                               instr_ready_i;
  logic [riscv_mini_pkg::INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]                    pc_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Generic synchronous FIFO with flush; head data reads as zero when empty.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    pop_ok  = pop_i & ~empty_o;
    push_ok = push_i & (~full_o | pop_ok);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = wdata_i;
        wr_d        = wr_q + AW'(1);
      end
      if (pop_ok) rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response buffer,
// and redirect flush with drop counting of responses still in flight.
module fetch_unit
  import riscv_mini_pkg::*;
#(
  parameter int              PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEF),
  parameter int              FIFO_DEPTH = 2,
  parameter int              MAX_OUTST  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fetch_unit_if.master    bus,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = FW + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic            req, hs, resp_drop, push, pop;
  logic [FW-1:0]   fifo_count, tag_count;
  logic            fifo_full, fifo_empty, tag_full, tag_empty;
  logic [PC_W-1:0] tag_pc;
  logic [INSTR_W+PC_W-1:0] head;

  // Credit rule: every request granted already owns a buffer slot for its response
  always_comb begin
    req = 1'b0;
    if (!rst_i && !redirect_i && (outst_q < OW'(MAX_OUTST)) &&
        ((SW'(fifo_count) + SW'(outst_q)) < SW'(FIFO_DEPTH)))
      req = 1'b1;
  end

  always_comb begin
    hs         = req & bus.imem_gnt_i;
    resp_drop  = bus.imem_rvalid_i & (drop_q != '0);
    push       = bus.imem_rvalid_i & ~resp_drop & ~redirect_i;
    pop        = ~fifo_empty & bus.instr_ready_i & ~redirect_i;
    outst_d    = outst_q + OW'(hs) - OW'(bus.imem_rvalid_i);
    drop_d     = drop_q - OW'(resp_drop);
    fetch_pc_d = fetch_pc_q;
    if (hs) fetch_pc_d = fetch_pc_q + PC_W'(2);
    if (redirect_i) begin
      drop_d     = outst_d;
      fetch_pc_d = redirect_pc_i & ~PC_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.W(INSTR_W + PC_W), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i ({bus.imem_rdata_i, tag_pc}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Tag queue is never flushed: dropped responses still retire their tag in order
  fetch_fifo #(.W(PC_W), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .push_i  (hs),
    .wdata_i (fetch_pc_q),
    .pop_i   (bus.imem_rvalid_i),
    .rdata_o (tag_pc),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = ~fifo_empty;
  assign bus.instr_o       = head[INSTR_W+PC_W-1:PC_W];
  assign bus.pc_o          = head[PC_W-1:0];

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push |-> !fifo_full);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                   bus.imem_rvalid_i |-> (outst_q != '0) && !tag_empty);
  a_tag_room:     assert property (@(posedge clk_i) disable iff (rst_i) hs |-> !tag_full);
  a_tag_tracks:   assert property (@(posedge clk_i) disable iff (rst_i) tag_count == FW'(outst_q));
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expectations queued at grant, compared at decode transfer.
module tb_fetch_unit;
  import riscv_mini_pkg::*;

  typedef struct packed {logic [15:0] instr; logic [15:0] pc;} exp_t;
  typedef struct packed {logic [15:0] addr; logic [31:0] due;} pend_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = '0;

  fetch_unit_if #(.PC_W(16)) bus ();

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .FIFO_DEPTH(2), .MAX_OUTST(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  int          errs = 0, checks = 0, cyc = 0;
  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [15:0] exp_pc = 16'h0000, prev_gaddr = 16'h0000, first_gaddr = 16'hFFFF;
  logic [15:0] redir_pc = '0, chk_pc_val = '0;
  logic        gnt_en = 1'b1, rdy_en = 1'b1, redir_req = 1'b0, chk_pc_en = 1'b0;
  logic        post_redir = 1'b0, saw_wrap = 1'b0, last_req = 1'b0, last_valid = 1'b0;
  int          lat = 1, dly_left = 3, first_gnt = -1, first_valid = -1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    exp_t  e;
    pend_t p;
    @(negedge clk_i);
    redirect_i    = redir_req;
    redirect_pc_i = redir_pc;
    if (pend.size() > 0 && pend[0].due <= 32'(cyc)) begin
      p = pend.pop_front();
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(p.addr);
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 16'($urandom);
    end
    bus.instr_ready_i = rdy_en;
    #1;
    // Withhold grant on the first few requests for 0x0004
    if (dly_left > 0 && bus.imem_req_o && bus.imem_addr_o == 16'h0004) begin
      bus.imem_gnt_i = 1'b0;
      dly_left--;
    end else begin
      bus.imem_gnt_i = gnt_en;
    end
    #1;
    last_req   = bus.imem_req_o;
    last_valid = bus.instr_valid_o;
    if (post_redir) begin
      chk("valid_after_redirect", 32'(bus.instr_valid_o), 32'd0);
      post_redir = 1'b0;
    end
    if (redirect_i) begin
      chk("req_on_redirect", 32'(bus.imem_req_o), 32'd0);
      exp_q.delete();
      exp_pc     = redirect_pc_i & 16'hFFFE;
      post_redir = 1'b1;
    end else begin
      if (bus.imem_req_o && bus.imem_gnt_i) begin
        chk("imem_addr", 32'(bus.imem_addr_o), 32'(exp_pc));
        if (exp_pc == 16'h0000 && prev_gaddr == 16'hFFFE) saw_wrap = 1'b1;
        prev_gaddr = exp_pc;
        if (first_gnt < 0) begin
          first_gnt   = cyc;
          first_gaddr = bus.imem_addr_o;
        end
        exp_q.push_back('{instr: mem_word(exp_pc), pc: exp_pc});
        pend.push_back('{addr: bus.imem_addr_o, due: 32'(cyc + lat)});
        exp_pc = exp_pc + 16'd2;
      end
      if (bus.instr_valid_o && first_valid < 0) first_valid = cyc;
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("instr_o", 32'(bus.instr_o), 32'(e.instr));
          chk("pc_o", 32'(bus.pc_o), 32'(e.pc));
          if (chk_pc_en) begin
            chk("first_pc_after_redirect", 32'(bus.pc_o), 32'(chk_pc_val));
            chk_pc_en = 1'b0;
          end
        end
      end
    end
    redir_req = 1'b0;
    @(posedge clk_i);
    cyc++;
  endtask

  task automatic wait_pend(input int n);
    int t = 0;
    while (pend.size() < n && t < 40) begin
      cycle();
      t++;
    end
    chk("wait_pend_timeout", 32'(pend.size() >= n), 32'd1);
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redir_req  = 1'b1;
    redir_pc   = pc;
    chk_pc_en  = 1'b1;
    chk_pc_val = pc & 16'hFFFE;
    cycle();
  endtask

  initial begin
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.instr_ready_i = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req_o), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst_instr", 32'(bus.instr_o), 32'd0);
    chk("rst_pc", 32'(bus.pc_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Sequential stream with a held request at 0x0004
    repeat (30) cycle();
    chk("first_valid_latency", 32'(first_valid - first_gnt), 32'd2);
    chk("first_addr", 32'(first_gaddr), 32'h0000);
    chk("gnt_delay_consumed", 32'(dly_left), 32'd0);

    // Decode stall
    rdy_en = 1'b0;
    repeat (10) cycle();
    chk("stall_req_low", 32'(last_req), 32'd0);
    chk("stall_valid_high", 32'(last_valid), 32'd1);
    rdy_en = 1'b1;
    repeat (12) cycle();

    // Redirect with two requests in flight
    lat = 3;
    wait_pend(2);
    chk("outst_before_redirect", 32'(pend.size()), 32'd2);
    do_redirect(16'h0041);
    repeat (20) cycle();
    chk("redirect1_reached_decode", 32'(chk_pc_en), 32'd0);

    // Redirect coincident with gnt and rvalid
    lat = 1;
    repeat (6) cycle();
    wait_pend(1);
    do_redirect(16'h0100);
    do_redirect(16'h0200);
    repeat (12) cycle();
    chk("redirect2_reached_decode", 32'(chk_pc_en), 32'd0);

    // PC wrap
    do_redirect(16'hFFFC);
    repeat (14) cycle();
    chk("pc_wrap_seen", 32'(saw_wrap), 32'd1);

    // Reset mid-stream
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus.imem_req_o), 32'd0);
    chk("mid_rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("mid_rst_instr", 32'(bus.instr_o), 32'd0);
    chk("mid_rst_pc", 32'(bus.pc_o), 32'd0);
    pend.delete();
    exp_q.delete();
    exp_pc            = 16'h0000;
    first_gnt         = -1;
    first_gaddr       = 16'hFFFF;
    bus.imem_rvalid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (12) cycle();
    chk("restart_addr", 32'(first_gaddr), 32'h0000);

    // Drain
    gnt_en = 1'b0;
    repeat (8) cycle();
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_pend_empty", 32'(pend.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
